// File: rtl/lockin_mixer_accumulator_pkg.sv
// Shared definitions for the lock-in mixer/accumulator: FSM encoding, drain depth
// and the accumulator width derivation also used by the downstream result FIFO.
package lockin_mixer_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DRAIN_CYCLES = 2;

  // Sample x reference product width plus one bit per possible doubling of the count.
  function automatic int acc_width(input int in_w, input int ref_w, input int cnt_w);
    return in_w + ref_w + cnt_w;
  endfunction

endpackage

// File: rtl/lockin_mixer_accumulator_signed_mult_reg.sv
// Registered signed multiply with a valid bit that tracks the product.
// Latency 1 cycle; no backpressure, clear drops any product in flight.
module signed_mult_reg #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              in_vld,
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p,
  output logic                              p_vld
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p     <= '0;
      p_vld <= 1'b0;
    end else begin
      p_vld <= in_vld && !clear;
      if (in_vld) begin
        p <= a * b;
      end
    end
  end

endmodule

// File: rtl/lockin_mixer_accumulator.sv
// Lock-in mixer: multiplies each accepted sample by cos/sin references and sums over num_samples.
// Result appears 3 edges after the last sample edge as a one-cycle result_valid pulse; no backpressure.
module lockin_mixer_accumulator
  import lockin_mixer_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int REF_WIDTH = 16,
  parameter int CNT_WIDTH = 20,
  parameter int ACC_WIDTH = acc_width(IN_WIDTH, REF_WIDTH, CNT_WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        clear,
  input  logic [CNT_WIDTH-1:0]        num_samples,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  input  logic signed [REF_WIDTH-1:0] ref_cos,
  input  logic signed [REF_WIDTH-1:0] ref_sin,
  input  logic                        data_in_valid,
  output logic                        busy,
  output logic signed [ACC_WIDTH-1:0] x_out,
  output logic signed [ACC_WIDTH-1:0] y_out,
  output logic                        result_valid
);

  localparam int PROD_WIDTH = IN_WIDTH + REF_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES);

  state_t                        state;
  logic [CNT_WIDTH-1:0]          num_lat;
  logic [CNT_WIDTH-1:0]          cnt;
  logic [CNT_WIDTH-1:0]          cnt_inc;
  logic [1:0]                    drain_cnt;
  logic signed [ACC_WIDTH-1:0]   acc_x;
  logic signed [ACC_WIDTH-1:0]   acc_y;
  logic signed [PROD_WIDTH-1:0]  prod_x;
  logic signed [PROD_WIDTH-1:0]  prod_y;
  logic                          prod_x_vld;
  logic                          prod_y_vld;
  logic                          mult_in_vld;
  logic                          start_ok;

  assign mult_in_vld = (state == ST_RUN) && data_in_valid && !clear;
  assign start_ok    = (state == ST_IDLE) && start && (num_samples != '0);
  assign cnt_inc     = cnt + CNT_ONE;
  assign busy        = (state != ST_IDLE);

  signed_mult_reg #(.A_WIDTH(IN_WIDTH), .B_WIDTH(REF_WIDTH)) u_mult_cos (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .in_vld  (mult_in_vld),
    .a       (data_in),
    .b       (ref_cos),
    .p       (prod_x),
    .p_vld   (prod_x_vld)
  );

  signed_mult_reg #(.A_WIDTH(IN_WIDTH), .B_WIDTH(REF_WIDTH)) u_mult_sin (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .in_vld  (mult_in_vld),
    .a       (data_in),
    .b       (ref_sin),
    .p       (prod_y),
    .p_vld   (prod_y_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_x <= '0;
      acc_y <= '0;
    end else if (clear || start_ok) begin
      acc_x <= '0;
      acc_y <= '0;
    end else if (prod_x_vld && prod_y_vld) begin
      acc_x <= acc_x + ACC_WIDTH'(prod_x);
      acc_y <= acc_y + ACC_WIDTH'(prod_y);
    end
  end

  // DRAIN_CYCLES+1 cycles in DRAIN: the last product accumulates first, then the sums are stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      num_lat      <= '0;
      cnt          <= '0;
      drain_cnt    <= '0;
      x_out        <= '0;
      y_out        <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clear) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              num_lat <= num_samples;
              cnt     <= '0;
              state   <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (data_in_valid) begin
              cnt <= cnt_inc;
              if (cnt_inc == num_lat) begin
                drain_cnt <= '0;
                state     <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
              x_out        <= acc_x;
              y_out        <= acc_y;
              result_valid <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              drain_cnt <= drain_cnt + 2'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lockin_mixer_accumulator.sv
// Directed bench for lockin_mixer_accumulator: table of continuous runs plus
// hand-written reset, gap, abort and ignored-input sequences.
module tb_lockin_mixer_accumulator;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               clear;
  logic [19:0]        num_samples;
  logic signed [15:0] data_in;
  logic signed [15:0] ref_cos;
  logic signed [15:0] ref_sin;
  logic               data_in_valid;
  logic               busy;
  logic signed [51:0] x_out;
  logic signed [51:0] y_out;
  logic               result_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     num;
    int     data;
    int     cs;
    int     sn;
    longint ex;
    longint ey;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  lockin_mixer_accumulator dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .clear         (clear),
    .num_samples   (num_samples),
    .data_in       (data_in),
    .ref_cos       (ref_cos),
    .ref_sin       (ref_sin),
    .data_in_valid (data_in_valid),
    .busy          (busy),
    .x_out         (x_out),
    .y_out         (y_out),
    .result_valid  (result_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Steps until result_valid rises or the budget expires; k is edges waited.
  task automatic wait_result(output int k);
    k = 0;
    while (!result_valid && k < 20) begin
      step();
      k++;
    end
  endtask

  task automatic drive(input int d, input int c, input int s, input logic v);
    data_in       = 16'(d);
    ref_cos       = 16'(c);
    ref_sin       = 16'(s);
    data_in_valid = v;
  endtask

  initial begin
    int k;
    vecs[0] = '{num: 4, data: 100,    cs: 1,      sn: 0,      ex: 64'sd400,         ey: 64'sd0};
    vecs[1] = '{num: 4, data: 1000,   cs: 2,      sn: -3,     ex: 64'sd8000,        ey: -64'sd12000};
    vecs[2] = '{num: 2, data: -32768, cs: -32768, sn: 32767,  ex: 64'sd2147483648,  ey: -64'sd2147418112};
    vecs[3] = '{num: 1, data: -5,     cs: 7,      sn: 3,      ex: -64'sd35,         ey: -64'sd15};
    vecs[4] = '{num: 3, data: -32768, cs: 32767,  sn: -32768, ex: -64'sd3221127168, ey: 64'sd3221225472};

    reset_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    num_samples = '0;
    drive(0, 0, 0, 1'b0);
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_result_valid", result_valid, 0);
    chk("reset_x", x_out, 0);
    chk("reset_y", y_out, 0);
    step();
    reset_n = 1'b1;
    step();

    // Reset in the middle of an 8-sample run.
    start = 1'b1;
    num_samples = 20'd8;
    step();
    start = 1'b0;
    drive(50, 3, 2, 1'b1);
    repeat (3) step();
    chk("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_x", x_out, 0);
    drive(0, 0, 0, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    // Continuous runs; valid=1 with junk data in IDLE/DRAIN and start held during RUN.
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      num_samples = 20'(vecs[i].num);
      drive(9999, 9999, 9999, 1'b1);
      step();
      chk($sformatf("v%0d_busy_after_start", i), busy, 1);
      num_samples = 20'd7;
      drive(vecs[i].data, vecs[i].cs, vecs[i].sn, 1'b1);
      repeat (vecs[i].num) step();
      start = 1'b0;
      drive(9999, 9999, 9999, 1'b1);
      wait_result(k);
      chk($sformatf("v%0d_latency", i), k, 3);
      chk($sformatf("v%0d_busy_at_result", i), busy, 0);
      chk($sformatf("v%0d_x", i), x_out, vecs[i].ex);
      chk($sformatf("v%0d_y", i), y_out, vecs[i].ey);
      drive(0, 0, 0, 1'b0);
      step();
      chk($sformatf("v%0d_pulse_width", i), result_valid, 0);
      chk($sformatf("v%0d_idle_after", i), busy, 0);
    end

    // Gapped samples with two idle cycles between each.
    start = 1'b1;
    num_samples = 20'd3;
    step();
    start = 1'b0;
    drive(5, 1, 1, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    repeat (2) begin step(); chk("gap_busy", busy, 1); end
    drive(7, 1, -1, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    repeat (2) begin step(); chk("gap_busy", busy, 1); end
    drive(-2, 1, 1, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    wait_result(k);
    chk("gap_latency", k, 3);
    chk("gap_x", x_out, 10);
    chk("gap_y", y_out, -4);
    step();

    // Abort after 2 of 5 samples: no result, outputs keep the previous sums.
    start = 1'b1;
    num_samples = 20'd5;
    step();
    start = 1'b0;
    drive(123, 45, 67, 1'b1);
    repeat (2) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(0, 0, 0, 1'b0);
    chk("abort_busy", busy, 0);
    k = 0;
    repeat (8) begin step(); if (result_valid) k++; end
    chk("abort_no_result", k, 0);
    chk("abort_x_kept", x_out, 10);
    chk("abort_y_kept", y_out, -4);

    // start with num_samples==0 is ignored.
    start = 1'b1;
    num_samples = 20'd0;
    step();
    start = 1'b0;
    chk("zero_num_busy", busy, 0);
    k = 0;
    repeat (6) begin step(); if (result_valid || busy) k++; end
    chk("zero_num_quiet", k, 0);

    // clear beats start in the same IDLE cycle.
    start = 1'b1;
    clear = 1'b1;
    num_samples = 20'd3;
    step();
    start = 1'b0;
    clear = 1'b0;
    chk("clear_start_busy", busy, 0);
    step();
    chk("clear_start_still_idle", busy, 0);

    // A fresh run after the abort starts from zero sums.
    start = 1'b1;
    num_samples = 20'd2;
    step();
    start = 1'b0;
    drive(-3, 4, -5, 1'b1);
    repeat (2) step();
    drive(0, 0, 0, 1'b0);
    wait_result(k);
    chk("post_abort_latency", k, 3);
    chk("post_abort_x", x_out, -24);
    chk("post_abort_y", y_out, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
